mem_bus_arbiter: RTL and testbench

//  Shares one external memory bus between two requesters: port 0 (instruction fetch) and port 1 (data memory).

---
 rtl/mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one external memory bus between two requesters,
//               port 0 (instruction fetch) and port 1 (data memory).
//               One transaction is outstanding at a time. Simultaneous
//               requests are resolved round-robin, and a transaction that
//               sees no bus response within TIMEOUT_CYCLES is aborted with
//               an error pulse.
//
// Ports       : clk, reset          - clock and synchronous active-high reset
//               pN_addr/_write_val  - port N request address / write data
//               pN_read_en/_write_en- port N level requests (write wins)
//               pN_read_val         - port N read data, held between reads
//               pN_done / pN_error  - 1-cycle completion / timeout pulses
//               mem_addr/_write_val - bus address / write data
//               mem_read_en/_write_en - bus strobes (level)
//               mem_read_val        - bus read data, valid with mem_response
//               mem_response        - bus completion (level)
//               busy                - high whenever the FSM is not IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_read_en,
    input  logic                  p0_write_en,
    input  logic [DATA_WIDTH-1:0] p0_write_val,
    output logic [DATA_WIDTH-1:0] p0_read_val,
    output logic                  p0_done,
    output logic                  p0_error,

    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_read_en,
    input  logic                  p1_write_en,
    input  logic [DATA_WIDTH-1:0] p1_write_val,
    output logic [DATA_WIDTH-1:0] p1_read_val,
    output logic                  p1_done,
    output logic                  p1_error,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_val,
    input  logic [DATA_WIDTH-1:0] mem_read_val,
    input  logic                  mem_response,

    output logic                  busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // The counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int            c_CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam bit            c_TO_EN    = (TIMEOUT_CYCLES != 0);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic                  r_grant;
    logic [c_CW-1:0]       r_cnt;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_read_en;
    logic                  r_mem_write_en;
    logic [DATA_WIDTH-1:0] r_mem_write_val;

    logic [DATA_WIDTH-1:0] r_p0_read_val;
    logic [DATA_WIDTH-1:0] r_p1_read_val;
    logic                  r_p0_done;
    logic                  r_p1_done;
    logic                  r_p0_error;
    logic                  r_p1_error;

    // ------------------------------------------------------------------
    // Arbitration decision (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic w_req0;
    logic w_req1;
    logic w_grant;
    logic w_grant_wr;
    logic w_timeout;

    assign w_req0 = p0_read_en | p0_write_en;
    assign w_req1 = p1_read_en | p1_write_en;

    // On a tie the port that did not win last time is chosen; otherwise
    // whichever single port is requesting.
    assign w_grant    = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

    // A port asserting both strobes performs the write.
    assign w_grant_wr = w_grant ? p1_write_en : p0_write_en;

    assign w_timeout  = c_TO_EN && (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_last_grant    <= 1'b1;
            r_grant         <= 1'b0;
            r_cnt           <= '0;
            r_mem_addr      <= '0;
            r_mem_read_en   <= 1'b0;
            r_mem_write_en  <= 1'b0;
            r_mem_write_val <= '0;
            r_p0_read_val   <= '0;
            r_p1_read_val   <= '0;
            r_p0_done       <= 1'b0;
            r_p1_done       <= 1'b0;
            r_p0_error      <= 1'b0;
            r_p1_error      <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses by default.
            r_p0_done  <= 1'b0;
            r_p1_done  <= 1'b0;
            r_p0_error <= 1'b0;
            r_p1_error <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    // A response still high from the previous transaction
                    // must not be mistaken for completion of a new one.
                    if (!mem_response && (w_req0 || w_req1)) begin
                        r_grant         <= w_grant;
                        r_last_grant    <= w_grant;
                        r_mem_addr      <= w_grant ? p1_addr      : p0_addr;
                        r_mem_write_val <= w_grant ? p1_write_val : p0_write_val;
                        r_mem_write_en  <= w_grant_wr;
                        r_mem_read_en   <= ~w_grant_wr;
                        r_cnt           <= '0;
                        r_state         <= c_BUSY;
                    end
                end

                c_BUSY: begin
                    // Response takes priority over a coincident timeout.
                    if (mem_response) begin
                        r_mem_read_en  <= 1'b0;
                        r_mem_write_en <= 1'b0;
                        if (!r_mem_write_en) begin
                            if (r_grant) begin
                                r_p1_read_val <= mem_read_val;
                            end else begin
                                r_p0_read_val <= mem_read_val;
                            end
                        end
                        r_p0_done <= ~r_grant;
                        r_p1_done <= r_grant;
                        r_cnt     <= '0;
                        r_state   <= c_DONE;
                    end else if (w_timeout) begin
                        r_mem_read_en  <= 1'b0;
                        r_mem_write_en <= 1'b0;
                        r_p0_error     <= ~r_grant;
                        r_p1_error     <= r_grant;
                        r_cnt          <= '0;
                        r_state        <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_DONE: begin
                    // One dead cycle lets the finished requester drop its
                    // level request before IDLE samples requests again.
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_cnt          <= '0;
                    r_state        <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr      = r_mem_addr;
    assign mem_read_en   = r_mem_read_en;
    assign mem_write_en  = r_mem_write_en;
    assign mem_write_val = r_mem_write_val;

    assign p0_read_val   = r_p0_read_val;
    assign p1_read_val   = r_p1_read_val;
    assign p0_done       = r_p0_done;
    assign p1_done       = r_p1_done;
    assign p0_error      = r_p0_error;
    assign p1_error      = r_p1_error;

    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Directed scenarios
//               followed by randomized request/latency mixes, checked
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic          p0_read_en, p0_write_en, p1_read_en, p1_write_en;
    logic [DW-1:0] p0_write_val, p1_write_val, p0_read_val, p1_read_val;
    logic          p0_done, p0_error, p1_done, p1_error;
    logic          mem_read_en, mem_write_en, mem_response, busy;
    logic [DW-1:0] mem_write_val, mem_read_val;

    // Per-port request drivers, indexed by port number.
    logic          rd [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wv [2];

    assign p0_read_en   = rd[0];
    assign p1_read_en   = rd[1];
    assign p0_write_en  = wr[0];
    assign p1_write_en  = wr[1];
    assign p0_addr      = ad[0];
    assign p1_addr      = ad[1];
    assign p0_write_val = wv[0];
    assign p1_write_val = wv[1];

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p0_addr       (p0_addr),
        .p0_read_en    (p0_read_en),
        .p0_write_en   (p0_write_en),
        .p0_write_val  (p0_write_val),
        .p0_read_val   (p0_read_val),
        .p0_done       (p0_done),
        .p0_error      (p0_error),
        .p1_addr       (p1_addr),
        .p1_read_en    (p1_read_en),
        .p1_write_en   (p1_write_en),
        .p1_write_val  (p1_write_val),
        .p1_read_val   (p1_read_val),
        .p1_done       (p1_done),
        .p1_error      (p1_error),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_write_val (mem_write_val),
        .mem_read_val  (mem_read_val),
        .mem_response  (mem_response),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: who won last, and each port's last read data.
    int            m_last;
    logic [DW-1:0] m_rv [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_rd"}, mem_read_en, 1'b0);
        chk1({tag, "_wr"}, mem_write_en, 1'b0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wval"}, mem_write_val, 32'h0);
        chk({tag, "_rv0"}, p0_read_val, 32'h0);
        chk({tag, "_rv1"}, p1_read_val, 32'h0);
        chk1({tag, "_pulses"}, p0_done | p1_done | p0_error | p1_error, 1'b0);
    endtask

    // Serve one bus transaction. The expected winner comes from the
    // currently held requests and the model's last grant. exp_wait is the
    // number of clock edges until the strobe should first be visible; lat
    // is the strobe cycle in which the bus responds (beyond TO = timeout).
    task automatic serve_one(input int exp_wait, input int lat, input bit drop_early,
                             input logic [DW-1:0] rdata);
        bit q0, q1, isw, ok, success;
        int p, n, ncyc;
        q0 = rd[0] | wr[0];
        q1 = rd[1] | wr[1];
        p  = (q0 && q1) ? ((m_last == 0) ? 1 : 0) : (q1 ? 1 : 0);
        isw = wr[p];
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            tick();
            n++;
            if (mem_read_en || mem_write_en) ok = 1'b1;
        end
        chk1("strobe_seen", ok, 1'b1);
        if (!ok) return;
        chk("grant_latency", 32'(n), 32'(exp_wait));
        m_last  = p;
        success = (lat <= TO);
        ncyc    = success ? lat : TO;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) tick();
            chk1("strobe_wr", mem_write_en, isw);
            chk1("strobe_rd", mem_read_en, !isw);
            chk("bus_addr", mem_addr, ad[p]);
            if (isw) chk("bus_wval", mem_write_val, wv[p]);
            chk1("busy_held", busy, 1'b1);
            chk1("no_early_pulse", p0_done | p1_done | p0_error | p1_error, 1'b0);
            if (drop_early && k == 1) begin
                rd[p] = 1'b0;
                wr[p] = 1'b0;
            end
            if (k == lat) begin
                mem_response = 1'b1;
                mem_read_val = rdata;
            end
        end
        tick();
        if (success && !isw) m_rv[p] = rdata;
        chk1("done0",  p0_done,  (p == 0) && success);
        chk1("done1",  p1_done,  (p == 1) && success);
        chk1("error0", p0_error, (p == 0) && !success);
        chk1("error1", p1_error, (p == 1) && !success);
        chk1("strobe_off", mem_read_en | mem_write_en, 1'b0);
        chk1("busy_done", busy, 1'b1);
        chk("read_val0", p0_read_val, m_rv[0]);
        chk("read_val1", p1_read_val, m_rv[1]);
        mem_response = 1'b0;
        mem_read_val = $urandom;
        rd[p] = 1'b0;
        wr[p] = 1'b0;
    endtask

    task automatic idle_check();
        tick();
        chk1("busy_clear", busy, 1'b0);
        chk1("idle_strobe", mem_read_en | mem_write_en, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  mode;
        logic [31:0] tmp;
        int          nreq;

        reset        = 1'b1;
        mem_response = 1'b0;
        mem_read_val = '0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wv[i] = '0; m_rv[i] = '0;
        end
        m_last = 1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Port 0 read, response after three strobe cycles.
        rd[0] = 1'b1; ad[0] = 32'h40;
        serve_one(1, 3, 1'b0, 32'hDEADBEEF);
        chk("t1_rdata", p0_read_val, 32'hDEADBEEF);
        idle_check();

        // Simultaneous requests right after reset: port 0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last = 1; m_rv[0] = '0; m_rv[1] = '0;
        tick();
        rd[0] = 1'b1; ad[0] = 32'h100;
        wr[1] = 1'b1; ad[1] = 32'h201; wv[1] = 32'hA5A5_0001;
        serve_one(1, 2, 1'b0, 32'h1111_2222);
        chk("t2_first_p0", p0_read_val, 32'h1111_2222);
        serve_one(2, 1, 1'b0, 32'h0);
        idle_check();

        // Port 1 write; its read data must not change.
        wr[1] = 1'b1; ad[1] = 32'h80; wv[1] = 32'h12345678;
        serve_one(1, 4, 1'b0, 32'hBAD0_BAD0);
        chk("t3_rv1_kept", p1_read_val, 32'h0);
        idle_check();

        // No response: timeout after exactly TO strobe cycles.
        rd[0] = 1'b1; ad[0] = 32'h300;
        serve_one(1, 100, 1'b0, 32'h0);
        idle_check();

        // Stale response while IDLE blocks the grant.
        mem_response = 1'b1;
        rd[1] = 1'b1; ad[1] = 32'h401;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("stale_no_strobe", mem_read_en | mem_write_en, 1'b0);
            chk1("stale_idle", busy, 1'b0);
        end
        mem_response = 1'b0;
        serve_one(1, 2, 1'b0, 32'hCAFE_F00D);
        idle_check();

        // Reset mid-transaction aborts silently.
        rd[0] = 1'b1; ad[0] = 32'h500;
        tick();
        chk1("abort_strobe", mem_read_en, 1'b1);
        tick();
        reset = 1'b1;
        rd[0] = 1'b0;
        tick();
        chk_all_zero("abort");
        reset = 1'b0;
        m_last = 1; m_rv[0] = '0; m_rv[1] = '0;
        tick();
        chk1("abort_no_pulse", p0_done | p0_error, 1'b0);
        wr[0] = 1'b1; ad[0] = 32'h600; wv[0] = 32'h0BAD_CAFE;
        serve_one(1, 2, 1'b0, 32'h0);
        idle_check();

        // Randomized request mixes, latencies and early drops.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++) begin
                mode  = 2'($urandom_range(0, 3));
                rd[i] = mode[0];
                wr[i] = mode[1];
                wv[i] = $urandom;
            end
            tmp   = $urandom;
            ad[0] = tmp & 32'hFFFF_FFFE;
            tmp   = $urandom;
            ad[1] = tmp | 32'h1;
            nreq  = int'(rd[0] | wr[0]) + int'(rd[1] | wr[1]);
            if (nreq >= 1)
                serve_one(1, $urandom_range(1, 10), ($urandom_range(0, 3) == 0), $urandom);
            if (nreq == 2)
                serve_one(2, $urandom_range(1, 10), ($urandom_range(0, 3) == 0), $urandom);
            idle_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
